// File: rtl/pdp8_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pdp8_pkg : PDP-8 widths, opcode/OPR microcode constants, decode types
// Revision : 1.0
// ------------------------------------------------------------------
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;
  localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;

  localparam logic [2:0] OP_AND = 3'o0;
  localparam logic [2:0] OP_TAD = 3'o1;
  localparam logic [2:0] OP_ISZ = 3'o2;
  localparam logic [2:0] OP_DCA = 3'o3;
  localparam logic [2:0] OP_JMS = 3'o4;
  localparam logic [2:0] OP_JMP = 3'o5;
  localparam logic [2:0] OP_IOT = 3'o6;
  localparam logic [2:0] OP_OPR = 3'o7;

  // Group 1
  localparam logic [11:0] OPR_NOP     = 12'o7000;
  localparam logic [11:0] OPR_IAC     = 12'o7001;
  localparam logic [11:0] OPR_RAL     = 12'o7004;
  localparam logic [11:0] OPR_RTL     = 12'o7006;
  localparam logic [11:0] OPR_RAR     = 12'o7010;
  localparam logic [11:0] OPR_RTR     = 12'o7012;
  localparam logic [11:0] OPR_CML     = 12'o7020;
  localparam logic [11:0] OPR_CMA     = 12'o7040;
  localparam logic [11:0] OPR_CIA     = 12'o7041;
  localparam logic [11:0] OPR_CLL     = 12'o7100;
  localparam logic [11:0] OPR_CLA1    = 12'o7200;
  localparam logic [11:0] OPR_CLA_CLL = 12'o7300;
  // Group 2
  localparam logic [11:0] OPR_CLA2    = 12'o7600;
  localparam logic [11:0] OPR_HLT     = 12'o7402;
  localparam logic [11:0] OPR_SMA     = 12'o7500;
  localparam logic [11:0] OPR_SZA     = 12'o7440;
  localparam logic [11:0] OPR_SNL     = 12'o7420;
  localparam logic [11:0] OPR_SPA     = 12'o7510;
  localparam logic [11:0] OPR_SNA     = 12'o7450;
  localparam logic [11:0] OPR_SZL     = 12'o7430;
  localparam logic [11:0] OPR_SKP     = 12'o7410;
  localparam logic [11:0] OPR_OSR     = 12'o7404;

  typedef struct packed {
    logic        AND;
    logic        TAD;
    logic        ISZ;
    logic        DCA;
    logic        JMS;
    logic        JMP;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic CLA2;
    logic HLT;
    logic SMA;
    logic SZA;
    logic SNL;
    logic SPA;
    logic SNA;
    logic SZL;
    logic SKP;
    logic OSR;
  } pdp_op7_opcode_s;

  typedef enum logic [3:0] {
    RST_WAIT  = 4'd0,
    CLR_ISSUE = 4'd1,
    WAIT_EXEC = 4'd2,
    FETCH     = 4'd3,
    DECODE    = 4'd4,
    IND_FETCH = 4'd5,
    IND_WAIT  = 4'd6,
    ISSUE     = 4'd7,
    HALTED    = 4'd8
  } ifd_state_e;

  function automatic pdp_mem_opcode_s mem_decode(input logic [2:0] op, input logic [11:0] addr);
    pdp_mem_opcode_s s;
    s = '0;
    s.mem_inst_addr = addr;
    case (op)
      OP_AND:  s.AND = 1'b1;
      OP_TAD:  s.TAD = 1'b1;
      OP_ISZ:  s.ISZ = 1'b1;
      OP_DCA:  s.DCA = 1'b1;
      OP_JMS:  s.JMS = 1'b1;
      OP_JMP:  s.JMP = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_decode_if.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_decode_if : memory / execution-unit bus of the fetch-decode unit
// Revision : 1.0
// ------------------------------------------------------------------
interface instr_fetch_decode_if;
  import pdp8_pkg::*;

  logic                  stall;
  logic [ADDR_WIDTH-1:0] PC_value;
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic [ADDR_WIDTH-1:0] base_addr;
  pdp_mem_opcode_s       pdp_mem_opcode;
  pdp_op7_opcode_s       pdp_op7_opcode;
  logic                  halted;

  modport master (
    input  stall, PC_value, ifu_rd_data,
    output ifu_rd_req, ifu_rd_addr, base_addr, pdp_mem_opcode, pdp_op7_opcode, halted
  );

  modport slave (
    output stall, PC_value, ifu_rd_data,
    input  ifu_rd_req, ifu_rd_addr, base_addr, pdp_mem_opcode, pdp_op7_opcode, halted
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_decode_op7_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// op7_decoder : combinational map from an instruction word to one-hot OPR struct
// Revision : 1.0
// ------------------------------------------------------------------
module op7_decoder
  import pdp8_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_ir,
  output pdp_op7_opcode_s       o_op7
);

  // Exact-match only; IOT and every unlisted OPR combination fall back to NOP.
  always_comb begin
    o_op7 = '0;
    case (i_ir)
      OPR_NOP:     o_op7.NOP     = 1'b1;
      OPR_IAC:     o_op7.IAC     = 1'b1;
      OPR_RAL:     o_op7.RAL     = 1'b1;
      OPR_RTL:     o_op7.RTL     = 1'b1;
      OPR_RAR:     o_op7.RAR     = 1'b1;
      OPR_RTR:     o_op7.RTR     = 1'b1;
      OPR_CML:     o_op7.CML     = 1'b1;
      OPR_CMA:     o_op7.CMA     = 1'b1;
      OPR_CIA:     o_op7.CIA     = 1'b1;
      OPR_CLL:     o_op7.CLL     = 1'b1;
      OPR_CLA1:    o_op7.CLA1    = 1'b1;
      OPR_CLA_CLL: o_op7.CLA_CLL = 1'b1;
      OPR_CLA2:    o_op7.CLA2    = 1'b1;
      OPR_HLT:     o_op7.HLT     = 1'b1;
      OPR_SMA:     o_op7.SMA     = 1'b1;
      OPR_SZA:     o_op7.SZA     = 1'b1;
      OPR_SNL:     o_op7.SNL     = 1'b1;
      OPR_SPA:     o_op7.SPA     = 1'b1;
      OPR_SNA:     o_op7.SNA     = 1'b1;
      OPR_SZL:     o_op7.SZL     = 1'b1;
      OPR_SKP:     o_op7.SKP     = 1'b1;
      OPR_OSR:     o_op7.OSR     = 1'b1;
      default:     o_op7.NOP     = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_fetch_decode : PDP-8 fetch, effective-address resolve and one-cycle issue
// Revision : 1.0
// ------------------------------------------------------------------
module instr_fetch_decode
  import pdp8_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDRESS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_fetch_decode_if.master bus
);

  ifd_state_e            r_state;
  logic                  r_stall_seen;
  logic [4:0]            r_pc_page;
  logic [2:0]            r_ir_op;
  logic                  r_rd_req;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  pdp_mem_opcode_s       r_mem_op;
  pdp_op7_opcode_s       r_op7_op;
  logic                  r_halted;

  logic [ADDR_WIDTH-1:0] w_ea;
  logic                  w_is_mem;
  pdp_op7_opcode_s       w_op7;

  op7_decoder u_op7_decoder (
    .i_ir  (bus.ifu_rd_data),
    .o_op7 (w_op7)
  );

  // Page base comes from the instruction's own address, not PC+1.
  assign w_ea     = bus.ifu_rd_data[7] ? {r_pc_page, bus.ifu_rd_data[6:0]}
                                       : {5'd0, bus.ifu_rd_data[6:0]};
  assign w_is_mem = (bus.ifu_rd_data[11:9] < OP_IOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RST_WAIT;
      r_stall_seen <= 1'b0;
      r_pc_page    <= '0;
      r_ir_op      <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_mem_op     <= '0;
      r_op7_op     <= '0;
      r_halted     <= 1'b0;
    end else begin
      // Strobes and issue structs are single-cycle unless set below.
      r_rd_req <= 1'b0;
      r_mem_op <= '0;
      r_op7_op <= '0;
      unique case (r_state)
        RST_WAIT: begin
          if (!bus.stall) begin
            r_op7_op.CLA_CLL <= 1'b1;
            r_state          <= CLR_ISSUE;
          end
        end
        CLR_ISSUE: begin
          r_stall_seen <= 1'b0;
          r_state      <= WAIT_EXEC;
        end
        WAIT_EXEC: begin
          if (bus.stall) begin
            r_stall_seen <= 1'b1;
          end else if (r_stall_seen) begin
            r_pc_page <= bus.PC_value[11:7];
            r_rd_req  <= 1'b1;
            r_rd_addr <= bus.PC_value;
            r_state   <= FETCH;
          end
        end
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_ir_op <= bus.ifu_rd_data[11:9];
          if (!w_is_mem) begin
            r_op7_op <= w_op7;
            r_state  <= ISSUE;
          end else if (bus.ifu_rd_data[8]) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= w_ea;
            r_state   <= IND_FETCH;
          end else begin
            r_mem_op <= mem_decode(bus.ifu_rd_data[11:9], w_ea);
            r_state  <= ISSUE;
          end
        end
        IND_FETCH: r_state <= IND_WAIT;
        IND_WAIT: begin
          // Auto-index cells are read as plain pointers; no write-back here.
          r_mem_op <= mem_decode(r_ir_op, bus.ifu_rd_data);
          r_state  <= ISSUE;
        end
        ISSUE: begin
          if (r_op7_op.HLT) begin
            r_halted <= 1'b1;
            r_state  <= HALTED;
          end else begin
            r_stall_seen <= 1'b0;
            r_state      <= WAIT_EXEC;
          end
        end
        HALTED: r_state <= HALTED;
        default: r_state <= RST_WAIT;
      endcase
    end
  end

  assign bus.ifu_rd_req     = r_rd_req;
  assign bus.ifu_rd_addr    = r_rd_addr;
  assign bus.base_addr      = START_ADDR;
  assign bus.pdp_mem_opcode = r_mem_op;
  assign bus.pdp_op7_opcode = r_op7_op;
  assign bus.halted         = r_halted;

endmodule
`default_nettype wire

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Synthesizable PDP-8 instruction fetch and decode unit that replaces the decode bus functional model in the full-chip build. It sits between the memory unit and the execution unit. It fetches the word at the PC supplied by the execution unit and resolves the effective address, including one level of indirection. It then presents a one-hot `pdp_mem_opcode` or `pdp_op7_opcode` struct for one cycle and waits for the execution unit to finish before fetching again.

## Interface
- `START_ADDR`, default `START_ADDRESS` (octal 0200): value driven on `base_addr`; the first PC the execution unit loads.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  high while the execution unit is busy; low means `PC_value` is valid.
- `PC_value`  in  `ADDR_WIDTH`  next PC from the execution unit.
- `ifu_rd_req`  out  1  one-cycle memory read strobe.
- `ifu_rd_addr`  out  `ADDR_WIDTH`  read address; held between requests.
- `ifu_rd_data`  in  `DATA_WIDTH`  read data; valid the cycle after `ifu_rd_req`.
- `base_addr`  out  `ADDR_WIDTH`  constant `START_ADDR`.
- `pdp_mem_opcode`  out  `pdp_mem_opcode_s`  fields AND, TAD, ISZ, DCA, JMS, JMP (one-hot) plus `mem_inst_addr[11:0]`.
- `pdp_op7_opcode`  out  `pdp_op7_opcode_s`  22 one-hot fields, MSB first: NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA1, CLA_CLL, CLA2, HLT, SMA, SZA, SNL, SPA, SNA, SZL, SKP, OSR.
- `halted`  out  1  high after an HLT has been issued.

## Operation
- States: RST_WAIT, CLR_ISSUE, WAIT_EXEC, FETCH, DECODE, IND_FETCH, IND_WAIT, ISSUE, HALTED.
- RST_WAIT: entered on reset. Stays here while `stall !== 0`, then goes to CLR_ISSUE.
- CLR_ISSUE: drives only CLA_CLL for one cycle, which clears AC and Link. Then goes to WAIT_EXEC.
- WAIT_EXEC: sets `stall_seen` when `stall=1`. In the first cycle with `stall_seen` set and `stall=0`, latches `PC_value` and goes to FETCH. The execution unit guarantees `stall=1` no later than one cycle after an ISSUE or CLR_ISSUE cycle.
- FETCH: `ifu_rd_req=1`, `ifu_rd_addr=PC`. Goes to DECODE.
- DECODE: latches `ifu_rd_data` as the instruction word `IR`.
  - `IR[11:9]` 0 to 5 is a memory reference.
  - Effective address `EA` = `IR[7]` ? {`PC[11:7]`, `IR[6:0]`} : {5'b0, `IR[6:0]`}.
  - If `IR[8]=1` (indirect), go to IND_FETCH; otherwise go to ISSUE with `mem_inst_addr=EA`.
- IND_FETCH: `ifu_rd_req=1`, `ifu_rd_addr=EA`. Goes to IND_WAIT.
- IND_WAIT: `mem_inst_addr = ifu_rd_data`. Goes to ISSUE.
  - Auto-index locations 0010 to 0017 octal are treated as plain indirect; this unit performs no writes.
- Opcode 6 (IOT) decodes to op7 NOP.
- Opcode 7, group 1 (`IR[8]=0`), exact match only:
  - 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR
  - 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA1, 7300 CLA_CLL
- Opcode 7, group 2 (`IR[8]=1`, `IR[0]=0`), exact match only:
  - 7402 HLT, 7500 SMA, 7440 SZA, 7420 SNL, 7510 SPA, 7450 SNA
  - 7430 SZL, 7410 SKP, 7600 CLA2, 7404 OSR
- Any other group-1, group-2 or group-3 OPR word decodes to NOP.
- ISSUE: exactly one struct field is high, for exactly one cycle. Both structs are all-zero in every other cycle.
  - After an HLT issue, go to HALTED and set `halted`.
  - Otherwise clear `stall_seen` and go to WAIT_EXEC.
- HALTED: absorbing state; no further `ifu_rd_req`. Only reset leaves it.

## Timing
- Reset values, applied immediately on the `reset_n` fall:
  - `ifu_rd_req=0`, `ifu_rd_addr=0`
  - both structs all-zero, `halted=0`
  - internal PC=0, IR=0, `stall_seen=0`, state RST_WAIT
- Reset asserted in any state, including mid-indirect, aborts the instruction; no partial struct is ever driven.
- All outputs are registered except `base_addr`, which is constant.
- Latency with request in cycle F: direct instruction issues in F+2; indirect issues in F+4 with its second request in F+2.
- `PC_value` sampled in cycle W gives the fetch request in W+1.
- Address arithmetic is 12-bit. The page base comes from the instruction's own address, so an instruction at 7777 octal uses page 7600 octal.

## Structure
- `pdp8_pkg` owns:
  - `pdp_mem_opcode_s` and `pdp_op7_opcode_s`
  - the opcode constants and the OPR microcode constants (octal)
  - `ADDR_WIDTH`, `DATA_WIDTH`, `START_ADDRESS`
  - a new `ifd_state_e` enum for the FSM states
- One natural sub-module: `op7_decoder`, a purely combinational map from 12-bit IR to `pdp_op7_opcode_s`, reused by the unit bench scoreboard.

## Test plan
- **Start-up:** reset, hold `stall=1` for 5 cycles, then release. Expect CLA_CLL for one cycle. Then the execution model pulses stall with `PC_value`=0200, and `ifu_rd_addr`=0200 with `ifu_rd_req` asserted the next cycle.
- **Current-page direct:** PC=0205, mem[0205]=1345. Expect TAD=1 with `mem_inst_addr`=0345, two cycles after the request.
- **Page-zero indirect:** PC=0300, mem[0300]=5410, mem[0010]=2345. Expect a second read at 0010, then JMP=1 with `mem_inst_addr`=2345 four cycles after the first request. mem[0010] must not be modified.
- **OPR decode:** 7041 gives only CIA. 7402 gives HLT, then `halted`=1 and no `ifu_rd_req` for 20 cycles of stall toggling.
- **Unsupported words:** 6032 and 7003 each give only op7 NOP, then a normal return to WAIT_EXEC.
- **Reset mid-operation:** assert `reset_n`=0 in IND_WAIT. Outputs go to zero the same cycle. After release the RST_WAIT → CLR_ISSUE sequence repeats.
